// File: rtl/tdc_cfg_pkg.sv
// Shared types and the chip's default register image for the TDC config sequencer.
// The default table is 11 entries: addresses 0-7, 11, 12 and 14.
package tdc_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_PULSE, S_R_HOLD, S_ADV, S_DONE, S_ERR
  } cfg_state_e;

  localparam int DEF_NUM_REGS = 11;

  localparam logic [27:0] REG0  = 28'h007_FC81;
  localparam logic [27:0] REG1  = 28'h000_0000;
  localparam logic [27:0] REG2  = 28'h000_0002;
  localparam logic [27:0] REG3  = 28'h000_0000;
  localparam logic [27:0] REG4  = 28'h600_0000;
  localparam logic [27:0] REG5  = 28'h0E0_04DA;
  localparam logic [27:0] REG6  = 28'h000_0000;
  localparam logic [27:0] REG7  = 28'h028_1FB4;
  localparam logic [27:0] REG11 = 28'h7FF_0000;
  localparam logic [27:0] REG12 = 28'h000_0000;
  localparam logic [27:0] REG14 = 28'h000_0000;

  function automatic logic [3:0] def_addr(input int unsigned idx);
    if (idx < 8) return 4'(idx);
    case (idx)
      8:       return 4'd11;
      9:       return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [27:0] def_data(input logic [3:0] a);
    case (a)
      4'd0:    return REG0;
      4'd1:    return REG1;
      4'd2:    return REG2;
      4'd3:    return REG3;
      4'd4:    return REG4;
      4'd5:    return REG5;
      4'd6:    return REG6;
      4'd7:    return REG7;
      4'd11:   return REG11;
      4'd12:   return REG12;
      default: return REG14;
    endcase
  endfunction

  function automatic logic def_rb(input logic [3:0] a);
    return (a == 4'd11) || (a == 4'd12);
  endfunction

endpackage

// File: rtl/tdc_cfg_rom.sv
// Default configuration table: index -> bus address, data and read-back flag.
// Kept outside the sequencer so a different table can be wired in its place.
module tdc_cfg_rom
  import tdc_cfg_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 28,
  parameter int IDX_W  = 4
) (
  input  logic [IDX_W-1:0]  cfg_idx,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  output logic              cfg_rb
);

  logic [3:0] a;

  assign a        = def_addr(32'(cfg_idx));
  assign cfg_addr = ADDR_W'(a);
  assign cfg_data = DATA_W'(def_data(a));
  assign cfg_rb   = def_rb(a);

endmodule

// File: rtl/tdc_cfg_sequencer.sv
// Walks the configuration table, writing each entry over the parallel bus with
// programmable setup/strobe/hold, optional read-back verify with retries.
module tdc_cfg_sequencer
  import tdc_cfg_pkg::*;
#(
  parameter int DATA_W    = 28,
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 11,
  parameter int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter int NUM_CH    = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int VERIFY    = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_rb,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              data_oe,
  input  logic [DATA_W-1:0] rdata,
  output logic              CSN,
  output logic              WRN,
  output logic              RDN,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM_CH-1:0] stop_dis
);

  localparam int PH_MAX = (SETUP_CYC > PULSE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int PH_W = $clog2(PH_MAX + 1);
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  cfg_state_e        state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d, ph_len;
  logic              ph_last;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oe_q, oe_d, csn_q, csn_d, wrn_q, wrn_d, rdn_q, rdn_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NUM_CH-1:0] sd_q, sd_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      retry_q <= '0;
      rb_q    <= '0;
      addr_q  <= '1;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sd_q    <= '1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      retry_q <= retry_d;
      rb_q    <= rb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      rdn_q   <= rdn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sd_q    <= sd_d;
    end
  end

  always_comb begin
    ph_len = PH_W'(1);
    case (state_q)
      S_W_SETUP:           ph_len = PH_W'(SETUP_CYC);
      S_W_PULSE, S_R_PULSE: ph_len = PH_W'(PULSE_CYC);
      S_W_HOLD, S_R_HOLD:  ph_len = PH_W'(HOLD_CYC);
      default:             ;
    endcase
  end

  assign ph_last = (ph_q == ph_len - PH_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_W_SETUP;
      S_W_SETUP: if (ph_last) state_d = S_W_PULSE;
      S_W_PULSE: if (ph_last) state_d = S_W_HOLD;
      S_W_HOLD:  if (ph_last) state_d = (VERIFY != 0 && cfg_rb) ? S_R_PULSE : S_ADV;
      S_R_PULSE: if (ph_last) state_d = S_R_HOLD;
      S_R_HOLD: if (ph_last) begin
        if (rb_q == wdata_q)                    state_d = S_ADV;
        else if (retry_q < RT_W'(MAX_RETRY))    state_d = S_W_SETUP;
        else                                    state_d = S_ERR;
      end
      S_ADV:   state_d = last_q ? S_DONE : S_W_SETUP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ph_d    = (state_d != state_q) ? '0 : ph_q + PH_W'(1);
    idx_d   = idx_q;
    last_d  = last_q;
    retry_d = retry_q;
    rb_d    = rb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // The index moves on entry to ADV so the table has a full cycle to settle
    // before the following W_SETUP edge latches it.
    if (state_d == S_ADV && state_q != S_ADV) begin
      if (idx_q == LAST_IDX) last_d = 1'b1;
      else                   idx_d  = idx_q + IDX_W'(1);
    end
    if (state_q == S_ADV && state_d == S_W_SETUP)    retry_d = '0;
    if (state_q == S_R_HOLD && state_d == S_W_SETUP) retry_d = retry_q + RT_W'(1);
    // Park the index at entry 0 once a run ends so a restart latches entry 0.
    if ((state_d == S_DONE || state_d == S_ERR) && state_d != state_q) begin
      idx_d  = '0;
      last_d = 1'b0;
    end
    if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) && state_d == S_W_SETUP) begin
      idx_d   = '0;
      last_d  = 1'b0;
      retry_d = '0;
    end
    if (state_q == S_R_PULSE && ph_last) rb_d = rdata;
    if (state_d == S_W_SETUP && state_q != S_W_SETUP) begin
      addr_d  = cfg_addr;
      wdata_d = cfg_data;
    end
    oe_d   = (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_HOLD);
    wrn_d  = (state_d != S_W_PULSE);
    rdn_d  = !(VERIFY != 0 && state_d == S_R_PULSE);
    csn_d  = wrn_d && rdn_d;
    busy_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    sd_d   = (state_d == S_DONE) ? '0 : '1;
  end

  assign cfg_idx  = idx_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign data_oe  = oe_q;
  assign CSN      = csn_q;
  assign WRN      = wrn_q;
  assign RDN      = rdn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign stop_dis = sd_q;

endmodule

// File: tb/tb_tdc_cfg_sequencer.sv
// Bench for tdc_cfg_sequencer: three configurations (plain, stretched timing,
// verify with an echoing/faulty bus) checked against a timeline model.
module tb_tdc_cfg_sequencer;
  localparam int N    = 11;
  localparam int MAXC = 128;
  localparam logic [3:0]  DEF_A [N] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd14};
  localparam logic [27:0] DEF_D [N] = '{28'h007FC81, 28'h0, 28'h0000002, 28'h0, 28'h6000000, 28'h0E004DA,
                                        28'h0, 28'h0281FB4, 28'h7FF0000, 28'h0, 28'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic tbl_sel = 1'b0, bad11 = 1'b0;
  logic [3:0]  rnd_addr [16];
  logic [27:0] rnd_data [16];
  int n_cmp = 0, n_bad = 0;
  int sel = 0;

  logic [3:0]  idx_a, ra_a, ca_a, addr_a, sd_a, idx_b, ra_b, addr_b, sd_b, idx_c, ra_c, addr_c, sd_c;
  logic [27:0] rd_a, cd_a, wd_a, rd_b, wd_b, rd_c, wd_c, rdata_c;
  logic rb_a, oe_a, CSN_a, WRN_a, RDN_a, busy_a, done_a, err_a;
  logic rb_b, oe_b, CSN_b, WRN_b, RDN_b, busy_b, done_b, err_b;
  logic rb_c, oe_c, CSN_c, WRN_c, RDN_c, busy_c, done_c, err_c;

  assign ca_a = tbl_sel ? rnd_addr[idx_a] : ra_a;
  assign cd_a = tbl_sel ? rnd_data[idx_a] : rd_a;

  tdc_cfg_rom u_rom_a (.cfg_idx(idx_a), .cfg_addr(ra_a), .cfg_data(rd_a), .cfg_rb(rb_a));
  tdc_cfg_rom u_rom_b (.cfg_idx(idx_b), .cfg_addr(ra_b), .cfg_data(rd_b), .cfg_rb(rb_b));
  tdc_cfg_rom u_rom_c (.cfg_idx(idx_c), .cfg_addr(ra_c), .cfg_data(rd_c), .cfg_rb(rb_c));

  tdc_cfg_sequencer #(.VERIFY(0)) u_a (
    .clk(clk), .reset_n(rst_n), .start(start_a), .cfg_idx(idx_a), .cfg_addr(ca_a), .cfg_data(cd_a),
    .cfg_rb(rb_a), .addr(addr_a), .wdata(wd_a), .data_oe(oe_a), .rdata(28'h0), .CSN(CSN_a), .WRN(WRN_a),
    .RDN(RDN_a), .busy(busy_a), .done(done_a), .err(err_a), .stop_dis(sd_a));
  tdc_cfg_sequencer #(.VERIFY(0), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_b (
    .clk(clk), .reset_n(rst_n), .start(start_b), .cfg_idx(idx_b), .cfg_addr(ra_b), .cfg_data(rd_b),
    .cfg_rb(rb_b), .addr(addr_b), .wdata(wd_b), .data_oe(oe_b), .rdata(28'h0), .CSN(CSN_b), .WRN(WRN_b),
    .RDN(RDN_b), .busy(busy_b), .done(done_b), .err(err_b), .stop_dis(sd_b));
  tdc_cfg_sequencer u_c (
    .clk(clk), .reset_n(rst_n), .start(start_c), .cfg_idx(idx_c), .cfg_addr(ra_c), .cfg_data(rd_c),
    .cfg_rb(rb_c), .addr(addr_c), .wdata(wd_c), .data_oe(oe_c), .rdata(rdata_c), .CSN(CSN_c), .WRN(WRN_c),
    .RDN(RDN_c), .busy(busy_c), .done(done_c), .err(err_c), .stop_dis(sd_c));

  // Bus model for the verify instance: a register file that echoes writes.
  logic [27:0] mem [16];
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (!CSN_c && !WRN_c) mem[addr_c] <= wd_c;
  end
  assign rdata_c = (bad11 && addr_c == 4'd11) ? 28'h0 : mem[addr_c];

  wire        m_wrn  = (sel == 0) ? WRN_a  : (sel == 1) ? WRN_b  : WRN_c;
  wire        m_rdn  = (sel == 0) ? RDN_a  : (sel == 1) ? RDN_b  : RDN_c;
  wire        m_csn  = (sel == 0) ? CSN_a  : (sel == 1) ? CSN_b  : CSN_c;
  wire        m_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  wire        m_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  wire        m_err  = (sel == 0) ? err_a  : (sel == 1) ? err_b  : err_c;
  wire [3:0]  m_addr = (sel == 0) ? addr_a : (sel == 1) ? addr_b : addr_c;
  wire [3:0]  m_sd   = (sel == 0) ? sd_a   : (sel == 1) ? sd_b   : sd_c;
  wire [27:0] m_wd   = (sel == 0) ? wd_a   : (sel == 1) ? wd_b   : wd_c;

  logic s_wrn [MAXC], s_rdn [MAXC], s_csn [MAXC], s_done [MAXC], s_busy [MAXC], s_err [MAXC];
  logic [3:0]  s_addr [MAXC], s_sd [MAXC];
  logic [27:0] s_wd [MAXC];
  int wt[$], wl[$], rt[$];
  logic [3:0]  wa[$], ra[$];
  logic [27:0] wdq[$];
  int first_done, first_err, v_cs, v_aw;

  task automatic kick();
    start_a = (sel == 0); start_b = (sel == 1); start_c = (sel == 2);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Snapshot k is taken after edge k, edge 0 being the one that sampled start.
  task automatic capture(input int n, input int poke);
    for (int k = 0; k < n; k++) begin
      s_wrn[k] = m_wrn; s_rdn[k] = m_rdn; s_csn[k] = m_csn; s_done[k] = m_done;
      s_busy[k] = m_busy; s_err[k] = m_err; s_addr[k] = m_addr; s_sd[k] = m_sd; s_wd[k] = m_wd;
      start_a = (sel == 0 && k == poke); start_b = (sel == 1 && k == poke); start_c = (sel == 2 && k == poke);
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    wt.delete(); wl.delete(); rt.delete(); wa.delete(); ra.delete(); wdq.delete();
    first_done = -1; first_err = -1; v_cs = 0; v_aw = 0;
    for (int k = 0; k < n; k++) begin
      if (!s_wrn[k] && (k == 0 || s_wrn[k-1])) begin
        wt.push_back(k); wa.push_back(s_addr[k]); wdq.push_back(s_wd[k]); wl.push_back(0);
      end
      if (!s_wrn[k]) wl[wl.size()-1] = wl[wl.size()-1] + 1;
      if (!s_rdn[k] && (k == 0 || s_rdn[k-1])) begin rt.push_back(k); ra.push_back(s_addr[k]); end
      if (s_done[k] && first_done < 0) first_done = k;
      if (s_err[k] && first_err < 0) first_err = k;
      if (s_csn[k] !== (s_wrn[k] & s_rdn[k])) v_cs++;
      if (k > 0 && s_addr[k] !== s_addr[k-1] && !s_wrn[k]) v_aw++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (addr_a !== 4'hF) begin n_bad++; $display("FAIL rst_addr: got %h want f", addr_a); end
    n_cmp++; if (wd_a !== 28'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", wd_a); end
    n_cmp++; if ({oe_a, CSN_a, WRN_a, RDN_a} !== 4'b0111) begin n_bad++; $display("FAIL rst_strobes: got %b want 0111", {oe_a, CSN_a, WRN_a, RDN_a}); end
    n_cmp++; if ({busy_a, done_a, err_a} !== 3'b000) begin n_bad++; $display("FAIL rst_status: got %b want 000", {busy_a, done_a, err_a}); end
    n_cmp++; if (sd_a !== 4'hF) begin n_bad++; $display("FAIL rst_stop_dis: got %h want f", sd_a); end
    n_cmp++; if (idx_a !== 4'h0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", idx_a); end
    n_cmp++; if ({RDN_c, CSN_c, busy_c, sd_c} !== 7'b1101111) begin n_bad++; $display("FAIL rst_c: got %b want 1101111", {RDN_c, CSN_c, busy_c, sd_c}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Unverified run: entry j strobes at j*T+S for P cycles; done at N*T.
  task automatic check_plain(input string tag, input int s, input int p, input int h, input logic use_rnd);
    int t;
    logic [3:0] ea;
    logic [27:0] ed;
    t = s + p + h + 1;
    n_cmp++; if (wt.size() !== N) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", tag, wt.size(), N); end
    for (int j = 0; j < N && j < wt.size(); j++) begin
      ea = use_rnd ? rnd_addr[j] : DEF_A[j];
      ed = use_rnd ? rnd_data[j] : DEF_D[j];
      n_cmp++; if (wa[j] !== ea) begin n_bad++; $display("FAIL %s_addr[%0d]: got %h want %h", tag, j, wa[j], ea); end
      n_cmp++; if (wdq[j] !== ed) begin n_bad++; $display("FAIL %s_data[%0d]: got %h want %h", tag, j, wdq[j], ed); end
      n_cmp++; if (wt[j] !== j * t + s) begin n_bad++; $display("FAIL %s_time[%0d]: got %0d want %0d", tag, j, wt[j], j * t + s); end
      n_cmp++; if (wl[j] !== p) begin n_bad++; $display("FAIL %s_width[%0d]: got %0d want %0d", tag, j, wl[j], p); end
    end
    n_cmp++; if (first_done !== N * t) begin n_bad++; $display("FAIL %s_done: got %0d want %0d", tag, first_done, N * t); end
    n_cmp++; if (s_sd[N*t] !== 4'h0 || s_sd[N*t-1] !== 4'hF) begin n_bad++; $display("FAIL %s_stop_dis: got %h/%h want f/0", tag, s_sd[N*t-1], s_sd[N*t]); end
    n_cmp++; if (s_busy[N*t] !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end: got %b want 0", tag, s_busy[N*t]); end
    n_cmp++; if (rt.size() !== 0) begin n_bad++; $display("FAIL %s_reads: got %0d want 0", tag, rt.size()); end
    n_cmp++; if (v_cs !== 0 || v_aw !== 0) begin n_bad++; $display("FAIL %s_strobe_rules: got %0d/%0d want 0/0", tag, v_cs, v_aw); end
  endtask

  task automatic test_default();
    sel = 0; tbl_sel = 1'b0;
    kick(); capture(50, -1);
    check_plain("dflt", 1, 1, 1, 1'b0);
  endtask

  task automatic test_random_table();
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      rnd_addr[i] = 4'($urandom_range(0, 15));
      rnd_data[i] = 28'($urandom);
    end
    tbl_sel = 1'b1;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    kick(); capture(50, -1);
    check_plain("rnd", 1, 1, 1, 1'b1);
    tbl_sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 0;
    n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL b2b_pre_done: got %b want 1", done_a); end
    kick(); capture(50, $urandom_range(2, 40));
    n_cmp++; if ({s_done[0], s_busy[0], s_sd[0]} !== 6'b011111) begin n_bad++; $display("FAIL b2b_restart: got %b want 011111", {s_done[0], s_busy[0], s_sd[0]}); end
    check_plain("b2b", 1, 1, 1, 1'b0);
  endtask

  task automatic test_stretched();
    int bad;
    sel = 1;
    kick(); capture(100, -1);
    check_plain("slow", 2, 3, 2, 1'b0);
    bad = 0;
    for (int j = 0; j < N && j < wt.size(); j++)
      for (int k = wt[j] - 2; k <= wt[j] + 4; k++)
        if (k >= 0 && s_addr[k] !== DEF_A[j]) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL slow_addr_stable: got %0d unstable cycles want 0", bad); end
  endtask

  // Verified run: entries at 11/12 add a read (2 cycles) per attempt.
  task automatic check_verify(input string tag);
    int t, nr;
    t = 0; nr = 0;
    n_cmp++; if (wt.size() !== N) begin n_bad++; $display("FAIL %s_count: got %0d want %0d", tag, wt.size(), N); end
    for (int j = 0; j < N && j < wt.size(); j++) begin
      n_cmp++; if (wa[j] !== DEF_A[j] || wt[j] !== t + 1) begin n_bad++; $display("FAIL %s_write[%0d]: got %h@%0d want %h@%0d", tag, j, wa[j], wt[j], DEF_A[j], t + 1); end
      if (DEF_A[j] == 4'd11 || DEF_A[j] == 4'd12) begin
        n_cmp++; if (nr >= rt.size() || ra[nr] !== DEF_A[j] || rt[nr] !== t + 3) begin n_bad++; $display("FAIL %s_read[%0d]: got %0d reads want addr %h at %0d", tag, j, rt.size(), DEF_A[j], t + 3); end
        nr++; t += 6;
      end else t += 4;
    end
    n_cmp++; if (rt.size() !== nr) begin n_bad++; $display("FAIL %s_read_count: got %0d want %0d", tag, rt.size(), nr); end
    n_cmp++; if (first_done !== t) begin n_bad++; $display("FAIL %s_done: got %0d want %0d", tag, first_done, t); end
    n_cmp++; if (first_err !== -1) begin n_bad++; $display("FAIL %s_err: got %0d want -1", tag, first_err); end
  endtask

  task automatic test_verify_fail();
    int n12;
    sel = 2; bad11 = 1'b1;
    kick(); capture(70, -1);
    n_cmp++; if (wt.size() !== 12) begin n_bad++; $display("FAIL vfail_writes: got %0d want 12", wt.size()); end
    n12 = 0;
    for (int j = 0; j < wt.size(); j++) begin
      if (wa[j] == 4'd12) n12++;
      if (j < 12) begin
        n_cmp++; if (wa[j] !== ((j < 8) ? DEF_A[j] : 4'd11) || wt[j] !== ((j < 8) ? 4 * j + 1 : 32 + 5 * (j - 8) + 1)) begin
          n_bad++; $display("FAIL vfail_write[%0d]: got %h@%0d", j, wa[j], wt[j]);
        end
      end
    end
    n_cmp++; if (n12 !== 0) begin n_bad++; $display("FAIL vfail_addr12: got %0d writes want 0", n12); end
    n_cmp++; if (rt.size() !== 4) begin n_bad++; $display("FAIL vfail_reads: got %0d want 4", rt.size()); end
    n_cmp++; if (first_err !== 52) begin n_bad++; $display("FAIL vfail_err_time: got %0d want 52", first_err); end
    n_cmp++; if ({s_busy[52], s_done[52], s_sd[52]} !== 6'b001111) begin n_bad++; $display("FAIL vfail_status: got %b want 001111", {s_busy[52], s_done[52], s_sd[52]}); end
  endtask

  task automatic test_err_restart();
    sel = 2; bad11 = 1'b0;
    kick(); capture(60, -1);
    n_cmp++; if ({s_err[0], s_busy[0]} !== 2'b01) begin n_bad++; $display("FAIL erst_clear: got %b want 01", {s_err[0], s_busy[0]}); end
    check_verify("erst");
  endtask

  task automatic test_reset_midrun();
    sel = 0;
    kick();
    repeat (21) @(negedge clk);
    n_cmp++; if ({WRN_a, CSN_a, addr_a} !== 6'b00_0101) begin n_bad++; $display("FAIL mid_pre: got %b want 000101", {WRN_a, CSN_a, addr_a}); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({WRN_a, CSN_a, addr_a, busy_a} !== 7'b11_1111_0) begin n_bad++; $display("FAIL mid_abort: got %b want 1111110", {WRN_a, CSN_a, addr_a, busy_a}); end
    rst_n = 1'b1;
    kick(); capture(50, -1);
    check_plain("mid", 1, 1, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_default();
    test_random_table();
    test_back_to_back();
    test_stretched();
    sel = 2; bad11 = 1'b0;
    kick(); capture(60, -1);
    check_verify("vecho");
    test_verify_fail();
    test_err_restart();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
